uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param
// Oversampling UART receiver. The serial line passes through a two-flop
// synchroniser. Each bit lasts P clocks, where P is 8, 16 or 32 and is
// latched from Prescale at the start of the frame. Each bit is decided by a
// 2-of-3 majority vote taken around the middle of the bit.
//
// Optional feature: define UART_RX_BREAK_DET_EN to add break detection and
// the Break_det output. The default build has no Break_det port, and an
// all-zero frame is reported as stop_error.
//
// Ports
//   CLK           rising-edge clock
//   Reset         synchronous active-low reset
//   S_Data        serial line (idle high, LSB first)
//   Parity_EN     parity bit present after the data bits
//   Parity_type   0 = even, 1 = odd
//   Stop_bits     0 = one stop bit, 1 = two stop bits
//   Prescale      clocks per bit (8/16/32; any other value is treated as 8)
//   P_Data        last word received without errors
//   Data_valid    one-cycle pulse when P_Data is loaded
//   Parity_error  one-cycle pulse on a parity mismatch
//   stop_error    one-cycle pulse when any stop bit is sampled 0
//   Break_det     one-cycle pulse on a line break (UART_RX_BREAK_DET_EN only)
//   Busy          high whenever the receiver is not idle
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a low level on the synchronised line
// START    | timing and voting on the start bit; a high vote is a glitch
// DATA     | shifting in DATA_WIDTH bits, LSB first
// PARITY   | voting on the parity bit
// STOP     | voting on one or two stop bits
// DONE     | one cycle in which the result pulses are high
// BRK_WAIT | after a break, wait for the line to stay high for one bit time

module uart_rx_param #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  S_Data,
    input  logic                  Parity_EN,
    input  logic                  Parity_type,
    input  logic                  Stop_bits,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_Data,
    output logic                  Data_valid,
    output logic                  Parity_error,
    output logic                  stop_error,
`ifdef UART_RX_BREAK_DET_EN
    output logic                  Break_det,
`endif
    output logic                  Busy
);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, DONE
`ifdef UART_RX_BREAK_DET_EN
        , BRK_WAIT
`endif
    } state_t;

    state_t                state;
    logic [1:0]            sync_q;
    logic                  rx;
    logic [5:0]            p_in;
    logic [5:0]            p_sel;
    logic [5:0]            half;
    logic [5:0]            last;
    logic [5:0]            tick;
    logic [3:0]            bit_idx;
    logic                  stop_idx;
    logic                  par_en_q;
    logic                  par_type_q;
    logic                  stop_bits_q;
    logic                  v0;
    logic                  v1;
    logic                  maj;
    logic                  maj_now;
    logic [DATA_WIDTH-1:0] data_sr;
    logic                  par_err_q;
    logic                  stop_err_q;
    logic                  stop_err_n;
    logic                  in_bit;
`ifdef UART_RX_BREAK_DET_EN
    logic                  all_zero;
    logic                  brk_q;
    logic                  brk_n;
`endif

    assign rx = sync_q[1];

    // Zero-extend before comparing, so that a narrow Prescale cannot alias 32.
    always_comb begin
        p_in = 6'd8;
        case (32'(Prescale))
            32'd16:  p_in = 6'd16;
            32'd32:  p_in = 6'd32;
            default: p_in = 6'd8;
        endcase
    end

    assign half    = p_sel >> 1;
    assign last    = p_sel - 6'd1;
    assign in_bit  = (state == START) || (state == DATA) ||
                     (state == PARITY) || (state == STOP);
    // The third vote is the live sample at tick half+1.
    assign maj_now = (v0 & v1) | (v0 & rx) | (v1 & rx);
    // maj holds the vote for the current bit from tick half+1 to tick P-1.
    assign stop_err_n = stop_err_q | ~maj;
    assign Busy = (state != IDLE);

`ifdef UART_RX_BREAK_DET_EN
    // With two stop bits, all_zero already includes the first stop vote.
    assign brk_n = all_zero & (stop_idx | ~maj);
`endif

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            sync_q       <= 2'b11;
            state        <= IDLE;
            p_sel        <= 6'd8;
            tick         <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            par_en_q     <= 1'b0;
            par_type_q   <= 1'b0;
            stop_bits_q  <= 1'b0;
            v0           <= 1'b1;
            v1           <= 1'b1;
            maj          <= 1'b1;
            data_sr      <= '0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            P_Data       <= '0;
            Data_valid   <= 1'b0;
            Parity_error <= 1'b0;
            stop_error   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            Break_det    <= 1'b0;
            all_zero     <= 1'b0;
            brk_q        <= 1'b0;
`endif
        end else begin
            sync_q       <= {sync_q[0], S_Data};
            Data_valid   <= 1'b0;
            Parity_error <= 1'b0;
            stop_error   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            Break_det    <= 1'b0;
`endif

            if (in_bit) begin
                if (tick == half - 6'd1) v0 <= rx;
                if (tick == half)        v1 <= rx;
                if (tick == half + 6'd1) maj <= maj_now;
                tick <= (tick == last) ? 6'd0 : tick + 6'd1;
            end

            case (state)
                IDLE: begin
                    if (!rx) begin
                        // The detecting cycle counts as tick 0 of the start
                        // bit. This keeps back-to-back frames from drifting.
                        state       <= START;
                        tick        <= 6'd1;
                        p_sel       <= p_in;
                        par_en_q    <= Parity_EN;
                        par_type_q  <= Parity_type;
                        stop_bits_q <= Stop_bits;
                        bit_idx     <= '0;
                        stop_idx    <= 1'b0;
                        par_err_q   <= 1'b0;
                        stop_err_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                        all_zero    <= 1'b1;
`endif
                    end
                end

                START: begin
                    if (tick == last) state <= maj ? IDLE : DATA;
                end

                DATA: begin
                    if (tick == last) begin
                        data_sr <= {maj, data_sr[DATA_WIDTH-1:1]};
`ifdef UART_RX_BREAK_DET_EN
                        if (maj) all_zero <= 1'b0;
`endif
                        if (bit_idx == 4'(DATA_WIDTH - 1)) begin
                            bit_idx <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end

                PARITY: begin
                    if (tick == last) begin
                        par_err_q <= ((^data_sr) ^ par_type_q) != maj;
`ifdef UART_RX_BREAK_DET_EN
                        if (maj) all_zero <= 1'b0;
`endif
                        state <= STOP;
                    end
                end

                STOP: begin
                    if (tick == last) begin
                        if (stop_bits_q && !stop_idx) begin
                            stop_idx   <= 1'b1;
                            stop_err_q <= stop_err_n;
`ifdef UART_RX_BREAK_DET_EN
                            if (maj) all_zero <= 1'b0;
`endif
                        end else begin
                            state    <= DONE;
                            stop_idx <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                            brk_q <= brk_n;
                            if (brk_n) begin
                                Break_det <= 1'b1;
                            end else
`endif
                            if (par_err_q || stop_err_n) begin
                                Parity_error <= par_err_q;
                                stop_error   <= stop_err_n;
                            end else begin
                                P_Data     <= data_sr;
                                Data_valid <= 1'b1;
                            end
                        end
                    end
                end

                DONE: begin
                    tick <= '0;
`ifdef UART_RX_BREAK_DET_EN
                    state <= brk_q ? BRK_WAIT : IDLE;
`else
                    state <= IDLE;
`endif
                end

`ifdef UART_RX_BREAK_DET_EN
                BRK_WAIT: begin
                    if (!rx) begin
                        tick <= '0;
                    end else if (tick == last) begin
                        tick  <= '0;
                        state <= IDLE;
                    end else begin
                        tick <= tick + 6'd1;
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
module tb_uart_rx_param;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       Reset, S_Data, Parity_EN, Parity_type, Stop_bits;
    logic [5:0] Prescale;
    logic [7:0] pd8;
    logic       dv8, pe8, se8, busy8;
    logic [8:0] pd9;
    logic       dv9, pe9, se9, busy9;

    uart_rx_param #(.DATA_WIDTH(8), .PRESCALE_W(6)) u8 (
        .CLK(CLK), .Reset(Reset), .S_Data(S_Data), .Parity_EN(Parity_EN),
        .Parity_type(Parity_type), .Stop_bits(Stop_bits), .Prescale(Prescale),
        .P_Data(pd8), .Data_valid(dv8), .Parity_error(pe8), .stop_error(se8),
        .Busy(busy8)
    );

    uart_rx_param #(.DATA_WIDTH(9), .PRESCALE_W(6)) u9 (
        .CLK(CLK), .Reset(Reset), .S_Data(S_Data), .Parity_EN(Parity_EN),
        .Parity_type(Parity_type), .Stop_bits(Stop_bits), .Prescale(Prescale),
        .P_Data(pd9), .Data_valid(dv9), .Parity_error(pe9), .stop_error(se9),
        .Busy(busy9)
    );

    typedef struct packed {
        logic       dv;
        logic       pe;
        logic       se;
        logic [8:0] pd;
    } ev_t;

    typedef struct packed {
        logic [5:0] pre;
        logic       pen;
        logic       ptype;
        logic       two;
        logic [7:0] d;
        logic       pbit;
        logic       s0;
        logic       s1;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pd;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    ev_t        e8[$];
    ev_t        e9[$];
    bit         en8 = 1'b0;
    bit         en9 = 1'b0;
    bit         mon = 1'b0;
    bit         rst_at_edge = 1'b0;
    logic [7:0] prev_pd8 = '0;
    logic [8:0] m_pd8 = '0;
    logic [8:0] m_pd9 = '0;

    always @(posedge CLK) rst_at_edge = Reset;

    // Every result pulse is matched, in order, against the expected queue.
    always @(negedge CLK) begin
        ev_t a;
        ev_t x;
        if (en8 && (dv8 || pe8 || se8)) begin
            a = '{dv: dv8, pe: pe8, se: se8, pd: {1'b0, pd8}};
            checks++;
            if (e8.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse_u8 got dv=%b pe=%b se=%b pd=%h required no pulse",
                         a.dv, a.pe, a.se, a.pd);
            end else begin
                x = e8.pop_front();
                if (a !== x) begin
                    failures++;
                    $display("FAIL frame_u8 got dv=%b pe=%b se=%b pd=%h required dv=%b pe=%b se=%b pd=%h",
                             a.dv, a.pe, a.se, a.pd, x.dv, x.pe, x.se, x.pd);
                end
            end
        end
        if (en9 && (dv9 || pe9 || se9)) begin
            a = '{dv: dv9, pe: pe9, se: se9, pd: pd9};
            checks++;
            if (e9.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse_u9 got dv=%b pe=%b se=%b pd=%h required no pulse",
                         a.dv, a.pe, a.se, a.pd);
            end else begin
                x = e9.pop_front();
                if (a !== x) begin
                    failures++;
                    $display("FAIL frame_u9 got dv=%b pe=%b se=%b pd=%h required dv=%b pe=%b se=%b pd=%h",
                             a.dv, a.pe, a.se, a.pd, x.dv, x.pe, x.se, x.pd);
                end
            end
        end
        // P_Data may only change together with Data_valid (or under reset).
        if (mon && rst_at_edge && !dv8) begin
            checks++;
            if (pd8 !== prev_pd8) begin
                failures++;
                $display("FAIL pdata_stable got %h required %h", pd8, prev_pd8);
            end
        end
        prev_pd8 = pd8;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    function automatic int bit_time(input logic [5:0] p);
        return (p == 6'd8 || p == 6'd16 || p == 6'd32) ? int'(p) : 8;
    endfunction

    function automatic bit odd_ones(input logic [8:0] v);
        return ($countones(v) % 2) == 1;
    endfunction

    // Reference: classify a frame from the bit values it carries.
    function automatic ev_t model(input int w, input logic [8:0] d, input bit pen,
                                  input bit ptype, input bit pbit, input bit two,
                                  input bit s0, input bit s1, input logic [8:0] last_pd);
        ev_t        r;
        logic [8:0] dm;
        bit         pexp;
        dm   = d & ((9'd1 << w) - 9'd1);
        pexp = odd_ones(dm) ^ ptype;
        r.se = !s0 || (two && !s1);
        r.pe = pen && (pbit != pexp);
        r.dv = !r.pe && !r.se;
        r.pd = r.dv ? dm : last_pd;
        return r;
    endfunction

    task automatic send_frame(input int w, input logic [8:0] d, input bit pen,
                              input bit ptype, input bit pbit, input bit two,
                              input bit s0, input bit s1, input logic [5:0] pre,
                              input int gap);
        int bt;
        bt          = bit_time(pre);
        Parity_EN   = pen;
        Parity_type = ptype;
        Stop_bits   = two;
        Prescale    = pre;
        S_Data = 1'b0;
        tick(bt);
        for (int i = 0; i < w; i++) begin
            S_Data = d[i];
            tick(bt);
        end
        if (pen) begin
            S_Data = pbit;
            tick(bt);
        end
        S_Data = s0;
        tick(bt);
        if (two) begin
            S_Data = s1;
            tick(bt);
        end
        S_Data = 1'b1;
        tick(gap);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((e8.size() != 0 || e9.size() != 0) && n < 3000) begin
            tick(1);
            n++;
        end
        tick(40);
        chk(name, 32'(e8.size() + e9.size()), 32'd0);
    endtask

    vec_t tv[8];

    initial begin
        ev_t        x;
        logic [5:0] pre;
        logic [7:0] d;
        bit         pen, ptype, two, pbit, s0, s1;
        int         cnt, r, bt;

        tv[0] = '{6'd8,  1'b1, 1'b0, 1'b0, 8'hD5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hD5};
        tv[1] = '{6'd8,  1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hD5};
        tv[2] = '{6'd16, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hD5};
        tv[3] = '{6'd32, 1'b1, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0F};
        tv[4] = '{6'd20, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81};
        tv[5] = '{6'd8,  1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h81};
        tv[6] = '{6'd16, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};
        tv[7] = '{6'd8,  1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF};

        Reset = 1'b0; S_Data = 1'b1; Parity_EN = 1'b0; Parity_type = 1'b0;
        Stop_bits = 1'b0; Prescale = 6'd8;
        tick(3);
        chk("rst_pdata8", 32'(pd8), 32'd0);
        chk("rst_pdata9", 32'(pd9), 32'd0);
        chk("rst_pulses", 32'({dv8, pe8, se8, dv9, pe9, se9}), 32'd0);
        chk("rst_busy",   32'({busy8, busy9}), 32'd0);
        Reset = 1'b1;
        tick(4);
        mon = 1'b1;
        en8 = 1'b1;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            e8.push_back('{dv: tv[i].dv, pe: tv[i].pe, se: tv[i].se, pd: {1'b0, tv[i].pd}});
            send_frame(8, {1'b0, tv[i].d}, tv[i].pen, tv[i].ptype, tv[i].pbit, tv[i].two,
                       tv[i].s0, tv[i].s1, tv[i].pre, 2 * bit_time(tv[i].pre));
        end
        wait_drain("table_drain");
        m_pd8 = 9'h0FF;

        // Short low glitches are rejected after one bit time.
        for (int g = 0; g < 2; g++) begin
            bt = (g == 0) ? 8 : 16;
            Prescale = 6'(bt); Parity_EN = 1'b0; Stop_bits = 1'b0;
            S_Data = 1'b0;
            cnt = 0;
            for (int i = 0; i < 60; i++) begin
                if (i == 3) S_Data = 1'b1;
                tick(1);
                if (busy8) cnt++;
            end
            checks++;
            if (cnt < bt - 1 || cnt > bt + 1) begin
                failures++;
                $display("FAIL glitch_busy_cycles got %0d required %0d..%0d", cnt, bt - 1, bt + 1);
            end
            chk("glitch_busy_low", 32'(busy8), 32'd0);
        end

        // Random frames against the reference model.
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 4);
            pre = (r == 0) ? 6'd8 : (r == 1) ? 6'd16 : (r == 2) ? 6'd32 :
                  (r == 3) ? 6'($urandom_range(0, 63)) : 6'd8;
            pen   = 1'($urandom_range(0, 1));
            ptype = 1'($urandom_range(0, 1));
            two   = 1'($urandom_range(0, 1));
            d     = 8'($urandom);
            pbit  = odd_ones({1'b0, d}) ^ ptype;
            if ($urandom_range(0, 3) == 0) pbit = ~pbit;
            s0 = ($urandom_range(0, 4) != 0);
            s1 = ($urandom_range(0, 4) != 0);
            x = model(8, {1'b0, d}, pen, ptype, pbit, two, s0, s1, m_pd8);
            m_pd8 = x.pd;
            e8.push_back(x);
            bt = bit_time(pre);
            send_frame(8, {1'b0, d}, pen, ptype, pbit, two, s0, s1, pre,
                       $urandom_range(1, bt));
        end
        wait_drain("random_drain");

        // Reset in the middle of the data bits aborts the frame silently.
        e8.push_back('{dv: 1'b1, pe: 1'b0, se: 1'b0, pd: 9'h0A5});
        send_frame(8, 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd8, 16);
        wait_drain("pre_reset_drain");
        Prescale = 6'd8; Parity_EN = 1'b0; Stop_bits = 1'b0;
        S_Data = 1'b0; tick(8);
        S_Data = 1'b1; tick(8);
        S_Data = 1'b0; tick(8);
        S_Data = 1'b1; tick(4);
        chk("mid_frame_busy", 32'(busy8), 32'd1);
        Reset = 1'b0; S_Data = 1'b1;
        tick(1);
        chk("abort_pdata", 32'(pd8), 32'd0);
        chk("abort_dv",    32'(dv8), 32'd0);
        chk("abort_pe",    32'(pe8), 32'd0);
        chk("abort_se",    32'(se8), 32'd0);
        chk("abort_busy",  32'(busy8), 32'd0);
        Reset = 1'b1;
        tick(20);
        e8.push_back('{dv: 1'b1, pe: 1'b0, se: 1'b0, pd: 9'h03C});
        send_frame(8, 9'h03C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd8, 16);
        wait_drain("after_reset_drain");
        chk("after_reset_pdata", 32'(pd8), 32'h3C);

        // 9-bit words at P=32 with odd parity, sent back to back.
        en8 = 1'b0;
        mon = 1'b0;
        Reset = 1'b0; tick(2); Reset = 1'b1; tick(4);
        en9 = 1'b1;
        m_pd9 = '0;
        pbit = odd_ones(9'h1A5) ^ 1'b1;
        x = model(9, 9'h1A5, 1'b1, 1'b1, pbit, 1'b0, 1'b1, 1'b1, m_pd9);
        m_pd9 = x.pd;
        e9.push_back(x);
        send_frame(9, 9'h1A5, 1'b1, 1'b1, pbit, 1'b0, 1'b1, 1'b1, 6'd32, 0);
        pbit = odd_ones(9'h05A) ^ 1'b1;
        x = model(9, 9'h05A, 1'b1, 1'b1, pbit, 1'b0, 1'b1, 1'b1, m_pd9);
        m_pd9 = x.pd;
        e9.push_back(x);
        send_frame(9, 9'h05A, 1'b1, 1'b1, pbit, 1'b0, 1'b1, 1'b1, 6'd32, 64);
        wait_drain("b2b_drain");
        chk("b2b_last_pdata", 32'(pd9), 32'h05A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
